// File: rtl/ad_avg_buf.sv
// Frame averager for the eight ADC channels: sums 2^AVG_LOG2 frames per channel and
// emits each averaged frame as eight tagged words through a first-word-fall-through FIFO.
module ad_avg_buf #(
  parameter int AVG_LOG2 = 2,
  parameter int CAP_DLY  = 256,
  parameter int FIFO_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               clr_err,
  input  logic               val_dat,
  input  logic [13:0]        ad_dat0,
  input  logic [13:0]        ad_dat1,
  input  logic [13:0]        ad_dat2,
  input  logic [13:0]        ad_dat3,
  input  logic [13:0]        ad_dat4,
  input  logic [13:0]        ad_dat5,
  input  logic [13:0]        ad_dat6,
  input  logic [13:0]        ad_dat7,
  input  logic               rd_en,
  output logic [17:0]        dout,
  output logic               empty,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               busy,
  output logic               frm_done,
  output logic               ovf,
  output logic               miss
);

  localparam int ACC_W = 14 + AVG_LOG2;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DLY_W = (CAP_DLY < 1) ? 1 : $clog2(CAP_DLY + 1);
  localparam int FC_W  = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
  localparam logic [FC_W-1:0]  FRM_LAST = FC_W'((1 << AVG_LOG2) - 1);
  localparam logic [FIFO_AW:0] CNT_ROOM = (FIFO_AW + 1)'(DEPTH - 8);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, EMIT} state_t;

  state_t            state, state_nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [FC_W-1:0]   frm_cnt;
  logic [2:0]        ch_idx;
  logic [ACC_W-1:0]  acc [8];
  logic [13:0]       ad_in [8];
  logic              val_dat_r;
  logic              edge_det;
  logic              wr_en, rd_do, drop, done, acc_add, acc_clr;
  logic [17:0]       wr_word;
  logic [17:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]  cnt;

  assign ad_in[0] = ad_dat0;
  assign ad_in[1] = ad_dat1;
  assign ad_in[2] = ad_dat2;
  assign ad_in[3] = ad_dat3;
  assign ad_in[4] = ad_dat4;
  assign ad_in[5] = ad_dat5;
  assign ad_in[6] = ad_dat6;
  assign ad_in[7] = ad_dat7;

  assign edge_det = val_dat & ~val_dat_r;
  assign wr_word  = {ch_idx == 3'd0, ch_idx, 14'(acc[ch_idx] >> AVG_LOG2)};

  // Room for a whole frame is decided once on EMIT entry; reads can only add space after that.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    done      = 1'b0;
    acc_add   = 1'b0;
    acc_clr   = 1'b0;
    case (state)
      IDLE: if (edge_det) state_nxt = WAIT;
      WAIT: if (dly_cnt <= DLY_W'(1)) state_nxt = ACC;
      ACC: begin
        acc_add   = 1'b1;
        state_nxt = (frm_cnt == FRM_LAST) ? EMIT : IDLE;
      end
      EMIT: begin
        if (ch_idx == 3'd0 && cnt > CNT_ROOM) begin
          drop      = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wr_en = 1'b1;
          if (ch_idx == 3'd7) begin
            done      = 1'b1;
            acc_clr   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      wr_en     = 1'b0;
      drop      = 1'b0;
      done      = 1'b0;
      acc_add   = 1'b0;
      acc_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      ch_idx    <= '0;
      frm_cnt   <= '0;
      val_dat_r <= 1'b0;
      frm_done  <= 1'b0;
      ovf       <= 1'b0;
      miss      <= 1'b0;
      for (int i = 0; i < 8; i++) acc[i] <= '0;
    end else begin
      state     <= state_nxt;
      val_dat_r <= val_dat;
      frm_done  <= done;
      if (state == IDLE && edge_det) dly_cnt <= DLY_W'(CAP_DLY);
      else if (state == WAIT)        dly_cnt <= dly_cnt - DLY_W'(1);
      if (flush)      ch_idx <= '0;
      else if (wr_en) ch_idx <= ch_idx + 3'd1;
      if (acc_clr) begin
        frm_cnt <= '0;
        for (int i = 0; i < 8; i++) acc[i] <= '0;
      end else if (acc_add) begin
        frm_cnt <= frm_cnt + FC_W'(1);
        for (int i = 0; i < 8; i++) acc[i] <= acc[i] + ACC_W'(ad_in[i]);
      end
      // A set event in the same cycle as clr_err keeps the flag raised.
      if (drop)         ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (edge_det && state != IDLE && !flush) miss <= 1'b1;
      else if (clr_err)                         miss <= 1'b0;
    end
  end

  assign rd_do = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_do) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, rd_do})
        2'b10:   cnt <= cnt + (FIFO_AW + 1)'(1);
        2'b01:   cnt <= cnt - (FIFO_AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign empty    = (cnt == '0);
  assign dout     = empty ? '0 : mem[rd_ptr];
  assign fifo_cnt = cnt;
  assign busy     = (state != IDLE);

endmodule
